// File: rtl/fifo_sel_pkg.sv
// fifo_sel_pkg: state encodings, defaults and helpers shared by the
// FIFO select arbiter and its priority picker.
package fifo_sel_pkg;

   localparam logic [1:0] ARB   = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   typedef enum logic [1:0] {
      S_ARB   = ARB,
      S_GRANT = GRANT,
      S_GAP   = GAP
   } arb_state_t;

   localparam int MAX_HOLD_DEF = 64;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_sel_arb_pick.sv
// rr_prio_pick: combinational rotating priority encoder; fixed mode
// searches from index 0, round-robin mode from ptr with wrap.
module rr_prio_pick
   import fifo_sel_pkg::*;
#(
   parameter  int N  = 16,
   localparam int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          rr_mode,
   output logic          any,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  onehot
);

   always_comb begin
      int base;
      int j;
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      j      = 0;
      base   = (rr_mode && (int'(ptr) < N)) ? int'(ptr) : 0;
      for (int i = 0; i < N; i++) begin
         j = base + i;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any       = 1'b1;
            idx       = IW'(j);
            onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_sel_arb.sv
// fifo_sel_arb: locks a grant on one FIFO request line until the owner
// drops it, releases it, or exceeds the maximum hold time.
module fifo_sel_arb
   import fifo_sel_pkg::*;
#(
   parameter  int PORT_NUM = 16,
   parameter  int MAX_HOLD = MAX_HOLD_DEF,
   localparam int IDX_W    = clog2(PORT_NUM)
) (
   input  logic                glb_clk,
   input  logic                glb_areset_n,
   input  logic [PORT_NUM-1:0] req_bits,
   input  logic                rr_mode,
   input  logic                lock_release,
   output logic                sel_valid,
   output logic [IDX_W-1:0]    sel_idx,
   output logic [PORT_NUM-1:0] sel_onehot,
   output logic                hold_timeout
);

   localparam int HC_RAW = clog2(MAX_HOLD + 1);
   localparam int HC_W   = (HC_RAW < 1) ? 1 : HC_RAW;

   localparam logic [HC_W-1:0] HOLD_LAST =
      HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORT_NUM - 1);

   arb_state_t          state_q;
   arb_state_t          state_d;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [IDX_W-1:0]    rr_ptr_d;
   logic [HC_W-1:0]     hold_cnt_q;
   logic [HC_W-1:0]     hold_cnt_d;
   logic                valid_d;
   logic [IDX_W-1:0]    idx_d;
   logic [PORT_NUM-1:0] oh_d;
   logic                to_d;

   logic                pick_any;
   logic [IDX_W-1:0]    pick_idx;
   logic [PORT_NUM-1:0] pick_oh;
   logic                rel_gone;
   logic                rel_time;

   rr_prio_pick #(
      .N (PORT_NUM)
   ) u_pick (
      .req     (req_bits),
      .ptr     (rr_ptr_q),
      .rr_mode (rr_mode),
      .any     (pick_any),
      .idx     (pick_idx),
      .onehot  (pick_oh)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      valid_d    = sel_valid;
      idx_d      = sel_idx;
      oh_d       = sel_onehot;
      to_d       = 1'b0;
      rel_gone   = ~|(req_bits & sel_onehot);
      rel_time   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

      unique case (state_q)
         S_ARB: begin
            if (pick_any) begin
               state_d    = S_GRANT;
               valid_d    = 1'b1;
               idx_d      = pick_idx;
               oh_d       = pick_oh;
               hold_cnt_d = '0;
               rr_ptr_d   = (pick_idx == LAST_IDX) ? '0
                                                   : pick_idx + IDX_W'(1);
            end
         end
         S_GRANT: begin
            if (rel_gone || lock_release || rel_time) begin
               state_d = S_GAP;
               valid_d = 1'b0;
               idx_d   = '0;
               oh_d    = '0;
               // timeout flagged only when it was the sole reason
               to_d    = rel_time & ~rel_gone & ~lock_release;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + HC_W'(1);
            end
         end
         S_GAP: begin
            state_d = S_ARB;
         end
         default: begin
            state_d = S_ARB;
            valid_d = 1'b0;
            idx_d   = '0;
            oh_d    = '0;
         end
      endcase
   end

   always_ff @(posedge glb_clk or negedge glb_areset_n) begin
      if (!glb_areset_n) begin
         state_q      <= S_ARB;
         rr_ptr_q     <= '0;
         hold_cnt_q   <= '0;
         sel_valid    <= 1'b0;
         sel_idx      <= '0;
         sel_onehot   <= '0;
         hold_timeout <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         hold_cnt_q   <= hold_cnt_d;
         sel_valid    <= valid_d;
         sel_idx      <= idx_d;
         sel_onehot   <= oh_d;
         hold_timeout <= to_d;
      end
   end

endmodule

// File: tb/tb_fifo_sel_arb.sv
// tb_fifo_sel_arb: vector table, corner sequences and a randomized run
// against a behavioural model of the grant/gap/timeout rules.
module tb_fifo_sel_arb;

   localparam int NA = 16;
   localparam int HA = 4;
   localparam int NB = 5;
   localparam int HB = 1;

   logic          glb_clk = 1'b0;
   logic          glb_areset_n = 1'b0;

   logic [NA-1:0] req_a = '0;
   logic          rr_a  = 1'b0;
   logic          rel_a = 1'b0;
   logic          v_a;
   logic [3:0]    idx_a;
   logic [NA-1:0] oh_a;
   logic          to_a;

   logic [NB-1:0] req_b = '0;
   logic          rr_b  = 1'b0;
   logic          rel_b = 1'b0;
   logic          v_b;
   logic [2:0]    idx_b;
   logic [NB-1:0] oh_b;
   logic          to_b;

   always #5 glb_clk = ~glb_clk;

   fifo_sel_arb #(.PORT_NUM(NA), .MAX_HOLD(HA)) u_dut_a (
      .glb_clk      (glb_clk),
      .glb_areset_n (glb_areset_n),
      .req_bits     (req_a),
      .rr_mode      (rr_a),
      .lock_release (rel_a),
      .sel_valid    (v_a),
      .sel_idx      (idx_a),
      .sel_onehot   (oh_a),
      .hold_timeout (to_a)
   );

   fifo_sel_arb #(.PORT_NUM(NB), .MAX_HOLD(HB)) u_dut_b (
      .glb_clk      (glb_clk),
      .glb_areset_n (glb_areset_n),
      .req_bits     (req_b),
      .rr_mode      (rr_b),
      .lock_release (rel_b),
      .sel_valid    (v_b),
      .sel_idx      (idx_b),
      .sel_onehot   (oh_b),
      .hold_timeout (to_b)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic [15:0] req;
      logic        rr;
      logic        rel;
      logic        ev;
      logic [3:0]  ei;
      logic        et;
   } vec_t;

   vec_t vt[$];

   // behavioural model state for the randomized phase
   bit m_valid;
   bit m_gap;
   bit m_to;
   int m_owner;
   int m_held;
   int m_ptr;

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk_a(input string nm, input bit ev, input int ei,
                        input bit et);
      logic [NA-1:0] eoh;
      eoh = ev ? (NA'(1) << ei) : '0;
      check({nm, ".valid"}, 64'(v_a), 64'(ev));
      check({nm, ".idx"}, 64'(idx_a), ev ? 64'(ei) : 64'(0));
      check({nm, ".onehot"}, 64'(oh_a), 64'(eoh));
      check({nm, ".tmo"}, 64'(to_a), 64'(et));
   endtask

   task automatic chk_b(input string nm, input bit ev, input int ei,
                        input bit et);
      logic [NB-1:0] eoh;
      eoh = ev ? (NB'(1) << ei) : '0;
      check({nm, ".valid"}, 64'(v_b), 64'(ev));
      check({nm, ".idx"}, 64'(idx_b), ev ? 64'(ei) : 64'(0));
      check({nm, ".onehot"}, 64'(oh_b), 64'(eoh));
      check({nm, ".tmo"}, 64'(to_b), 64'(et));
   endtask

   task automatic tick();
      @(posedge glb_clk);
      #1;
   endtask

   task automatic do_reset();
      glb_areset_n = 1'b0;
      #1;
      glb_areset_n = 1'b1;
      #1;
   endtask

   task automatic add(input bit rst, input logic [15:0] req,
                      input bit rr, input bit rel, input bit ev,
                      input int ei, input bit et);
      vec_t v;
      v.rst = rst;
      v.req = req;
      v.rr  = rr;
      v.rel = rel;
      v.ev  = ev;
      v.ei  = 4'(ei);
      v.et  = et;
      vt.push_back(v);
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_gap   = 0;
      m_to    = 0;
      m_owner = 0;
      m_held  = 0;
      m_ptr   = 0;
   endtask

   task automatic model_step(input logic [NA-1:0] rq, input bit rr,
                             input bit rl);
      bit gone;
      bit tmo;
      int base;
      m_to = 0;
      if (m_valid) begin
         gone = !rq[m_owner];
         tmo  = (HA != 0) && (m_held == HA);
         if (gone || rl || tmo) begin
            m_valid = 0;
            m_gap   = 1;
            m_to    = tmo && !gone && !rl;
         end else begin
            m_held++;
         end
      end else if (m_gap) begin
         m_gap = 0;
      end else if (rq != '0) begin
         base = rr ? m_ptr : 0;
         for (int i = 0; i < NA; i++) begin
            if (rq[(base + i) % NA]) begin
               m_owner = (base + i) % NA;
               break;
            end
         end
         m_valid = 1;
         m_held  = 1;
         m_ptr   = (m_owner + 1) % NA;
      end
   endtask

   initial begin
      int rr_seq[4];
      rr_seq = '{1, 15, 0, 1};

      glb_areset_n = 1'b0;
      #12;
      chk_a("reset_a", 0, 0, 0);
      chk_b("reset_b", 0, 0, 0);
      glb_areset_n = 1'b1;

      // fixed priority
      add(1, 16'h0130, 0, 0, 1, 4, 0);
      add(0, 16'h0120, 0, 0, 0, 0, 0);
      add(0, 16'h0120, 0, 0, 0, 0, 0);
      add(0, 16'h0120, 0, 0, 1, 5, 0);
      add(0, 16'h0000, 0, 0, 0, 0, 0);
      add(0, 16'h0000, 0, 0, 0, 0, 0);
      // round robin with wrap
      add(1, 16'h8003, 1, 0, 1, 0, 0);
      foreach (rr_seq[k]) begin
         add(0, 16'h8003, 1, 1, 0, 0, 0);
         add(0, 16'h8003, 1, 0, 0, 0, 0);
         add(0, 16'h8003, 1, 0, 1, rr_seq[k], 0);
      end
      add(0, 16'h8003, 1, 1, 0, 0, 0);
      add(0, 16'h0000, 1, 0, 0, 0, 0);
      // timeout, then release coinciding with timeout
      add(1, 16'h0080, 0, 0, 1, 7, 0);
      for (int k = 0; k < 3; k++) add(0, 16'h0080, 0, 0, 1, 7, 0);
      add(0, 16'h0080, 0, 0, 0, 0, 1);
      add(0, 16'h0080, 0, 0, 0, 0, 0);
      add(0, 16'h0080, 0, 0, 1, 7, 0);
      for (int k = 0; k < 3; k++) add(0, 16'h0080, 0, 0, 1, 7, 0);
      add(0, 16'h0080, 0, 1, 0, 0, 0);
      add(0, 16'h0080, 0, 0, 0, 0, 0);
      add(0, 16'h0080, 0, 0, 1, 7, 0);
      add(0, 16'h0000, 0, 0, 0, 0, 0);
      add(0, 16'h0000, 0, 0, 0, 0, 0);
      // lock: port 0 cannot pre-empt owner 2
      add(1, 16'h0004, 0, 0, 1, 2, 0);
      add(0, 16'h0005, 0, 0, 1, 2, 0);
      add(0, 16'h0005, 0, 0, 1, 2, 0);
      add(0, 16'h0005, 0, 1, 0, 0, 0);
      add(0, 16'h0005, 0, 0, 0, 0, 0);
      add(0, 16'h0005, 0, 0, 1, 0, 0);

      foreach (vt[n]) begin
         if (vt[n].rst) do_reset();
         req_a = vt[n].req;
         rr_a  = vt[n].rr;
         rel_a = vt[n].rel;
         tick();
         chk_a($sformatf("vec%0d", n), vt[n].ev, int'(vt[n].ei), vt[n].et);
      end

      // asynchronous reset in the middle of a grant
      req_a = '0;
      rel_a = 1'b0;
      do_reset();
      req_a = 16'h0010;
      rr_a  = 1'b1;
      tick();
      chk_a("mid_grant_pre", 1, 4, 0);
      req_a = 16'hFFFF;
      tick();
      chk_a("mid_grant_lock", 1, 4, 0);
      #3;
      glb_areset_n = 1'b0;
      #1;
      chk_a("mid_reset_a", 0, 0, 0);
      #1;
      glb_areset_n = 1'b1;
      tick();
      chk_a("after_reset_ptr0", 1, 0, 0);

      // non-power-of-two port count, MAX_HOLD of one
      req_a = '0;
      do_reset();
      req_b = 5'h1F;
      rr_b  = 1'b1;
      for (int g = 0; g < 6; g++) begin
         tick();
         chk_b($sformatf("np2_grant%0d", g), 1, g % NB, 0);
         tick();
         chk_b($sformatf("np2_gap%0d", g), 0, 0, 1);
         tick();
         chk_b($sformatf("np2_arb%0d", g), 0, 0, 0);
      end
      req_b = '0;

      // randomized run against the model
      do_reset();
      model_reset();
      req_a = '0;
      rr_a  = 1'b0;
      rel_a = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 4) == 0) req_a = '0;
            else req_a = NA'($urandom & $urandom);
         end
         rel_a = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) rr_a = ~rr_a;
         tick();
         model_step(req_a, rr_a, rel_a);
         chk_a($sformatf("rand%0d", c), m_valid, m_owner, m_to);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_sel_arb.md
# fifo_sel_arb

Parametrised arbiter that selects one of `PORT_NUM` FIFO request lines and locks the grant until the owner releases it. It supports fixed-priority or round-robin arbitration, an optional maximum-hold timeout and an explicit release input. All outputs are registered. It sits between the per-port FIFO non-empty/request flags and the shared read/forward path, and drives both an encoded index and a one-hot grant.

## Interface
- `PORT_NUM`, 16: number of request ports (2..64).
- `IDX_W`, `$clog2(PORT_NUM)`: localparam, width of `sel_idx`.
- `MAX_HOLD`, 64: maximum consecutive grant cycles per owner. 0 disables the timeout.
- `glb_clk`  in  1  clock; all logic is rising-edge.
- `glb_areset_n`  in  1  asynchronous, active-low reset; clock is `glb_clk`.
- `req_bits`  in  PORT_NUM  per-port request, level-sensitive.
- `rr_mode`  in  1  1 = round-robin, 0 = fixed priority (bit 0 highest). Sampled only in ARB.
- `lock_release`  in  1  owner-done pulse. Ends the current grant.
- `sel_valid`  out  1  grant active.
- `sel_idx`  out  IDX_W  index of the owner. Valid only while `sel_valid` is 1.
- `sel_onehot`  out  PORT_NUM  one-hot grant. All zero when `sel_valid` is 0.
- `hold_timeout`  out  1  one-cycle pulse: the previous grant was ended by the timeout.

## Operation
- **States**
  - ARB (reset state): no grant.
  - GRANT: owner locked.
  - GAP: one mandatory turnaround cycle.
- **ARB**
  - If `req_bits` is 0, stay in ARB.
  - Otherwise pick a winner:
    - Fixed mode: lowest set index.
    - RR mode: first set index at or after `rr_ptr`, searching upward with wrap.
  - Load the owner, set `hold_cnt` to 0 and go to GRANT.
- **GRANT**, release conditions evaluated every cycle:
  - (a) `req_bits[owner]` = 0
  - (b) `lock_release` = 1
  - (c) `MAX_HOLD` != 0 and `hold_cnt` = `MAX_HOLD`-1
- Any release condition goes to GAP. Otherwise `hold_cnt` increments.
- **GAP**: unconditionally returns to ARB. No grant is issued in GAP.
- **`rr_ptr`**
  - Width IDX_W, reset 0.
  - Loaded with `(owner+1) mod PORT_NUM` at each grant, in both modes.
  - Wrap: if owner is `PORT_NUM`-1, `rr_ptr` becomes 0. Applies to non-power-of-two `PORT_NUM` as well.
- **`hold_cnt`** width is `$clog2(MAX_HOLD+1)`. It saturates and never wraps.
- **Simultaneous release conditions**: `hold_timeout` is set only if (c) is true and both (a) and (b) are false.
- Requests from non-owners during GRANT are ignored. Ownership is never pre-empted.
- In fixed mode, a continuously requesting port 0 is regranted after every GAP. This is intended; the timeout only forces the gap.
- Changing `rr_mode` during GRANT has no effect until the next ARB.

## Timing
- **Reset values**: `sel_valid`=0, `sel_idx`=0, `sel_onehot`=0, `hold_timeout`=0, state ARB, `rr_ptr`=0, `hold_cnt`=0. Reset is asynchronous and takes effect immediately, including mid-grant.
- **Grant latency**: a request sampled in ARB at edge k gives `sel_valid`=1 after edge k.
- **Release**: a condition sampled at edge m clears `sel_valid` after edge m. A new grant is possible at the earliest after edge m+2 (GAP occupies the cycle after m).
- **Timeout**: an owner holds at most `MAX_HOLD` consecutive `sel_valid` cycles. `hold_timeout` is high for exactly the GAP cycle.
- **Outputs**: `sel_idx` and `sel_onehot` change only together with a `sel_valid` 0→1 transition. They clear to 0 when `sel_valid` falls.

## Structure
- Shared package `fifo_sel_pkg` holds:
  - the state encoding localparams (ARB=2'd0, GRANT=2'd1, GAP=2'd2);
  - the `clog2` helper function;
  - the default `MAX_HOLD`.
- One sub-module, `rr_prio_pick`: purely combinational rotating priority encoder.
  - Inputs: `req`, `ptr`, `rr_mode`.
  - Outputs: `any`, `idx`, `onehot`.
- Instantiate `rr_prio_pick` once. The FSM, counter and pointer stay in `fifo_sel_arb`.

## Test plan
- **Fixed priority**: reset, `rr_mode`=0, `req_bits`=16'h0130 → `sel_idx`=4 after one edge. Drop `req_bits[4]` → `sel_valid`=0 for one GAP cycle, then `sel_idx`=5.
- **Round-robin**: `rr_mode`=1, `req_bits`=16'h8003 held, `lock_release` pulsed each grant → grant order 0,1,15,0,1 (wrap check).
- **Timeout**: `MAX_HOLD`=4, `req_bits[7]` held alone.
  - Expect `sel_valid` high exactly 4 cycles, then a 1-cycle gap with `hold_timeout`=1, then regrant of 7.
  - Repeat with `lock_release` asserted in the timeout cycle → expect `hold_timeout`=0.
- **Lock**: owner 2 granted, `req_bits[0]` rises mid-grant with `rr_mode`=0 → `sel_idx` stays 2 until release.
- **Reset mid-grant**: assert `glb_areset_n`=0 during GRANT → all outputs 0 immediately. After release, `rr_ptr`=0 (verified with `req_bits`=16'hFFFF in RR mode → first grant is 0).
- **Non-power-of-two**: `PORT_NUM`=5, RR with all requests held and `MAX_HOLD`=1 → grant order 0,1,2,3,4,0, each grant separated by one gap cycle.
